ps_conv_hs: RTL and testbench

Parametrised, handshaked parallel/serial converter for the byte-serial AES datapath. It loads an N-word parallel block and unloads it one W-bit word per beat, most significant word first. On each beat it shifts a serial input word in at the bottom, so after N beats the captured serial words are presented as a parallel block. A valid/ready handshake on the serial side and a load handshake on the parallel side allow back-pressure and back-to-back blocks without idle cycles.

---
 rtl/ps_conv_hs.sv | 77 +++++++
 tb/tb_ps_conv_hs.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps_conv_hs.sv
// Parallel-to-serial unloader with serial-to-parallel capture; first dout word 1 cycle after load, one word per beat.
// Stalls hold dout and state; pld_ready combinationally reopens on the last beat so back-to-back blocks have no bubble.
module ps_conv_hs #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] pdin,
  input  logic           pld_valid,
  output logic           pld_ready,
  output logic [W-1:0]   dout,
  output logic           dout_valid,
  input  logic           dout_ready,
  input  logic [W-1:0]   din,
  output logic [N*W-1:0] pdout,
  output logic           pdout_valid,
  output logic           busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  logic           state;
  logic [CW-1:0]  cnt;
  logic [N*W-1:0] sreg;
  logic [N*W-1:0] shifted;
  logic           load;
  logic           beat;
  logic           last;

  // Word N-1 sits at the top of sreg so it leaves first; din enters word 0.
  if (N == 1) begin : g_one
    assign shifted = din;
  end else begin : g_multi
    assign shifted = {sreg[(N-1)*W-1:0], din};
  end

  assign beat       = dout_valid & dout_ready;
  assign last       = beat & (cnt == CW'(N - 1));
  assign pld_ready  = (state == ST_IDLE) | last;
  assign load       = pld_valid & pld_ready;
  assign dout       = sreg[N*W-1 -: W];
  assign dout_valid = (state == ST_SHIFT);
  assign busy       = (state == ST_SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      sreg        <= '0;
      pdout       <= '0;
      pdout_valid <= 1'b0;
    end else begin
      pdout_valid <= last;
      if (last) begin
        pdout <= shifted;
      end
      // A load while in SHIFT can only happen on the last beat, so it replaces the final shift.
      if (load) begin
        sreg  <= pdin;
        cnt   <= '0;
        state <= ST_SHIFT;
      end else if (beat) begin
        sreg <= shifted;
        if (last) begin
          cnt   <= '0;
          state <= ST_IDLE;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ps_conv_hs.sv
// Directed bench for ps_conv_hs: default (W=8,N=4) plus N=1/W=8 and N=16/W=1 corners.
module tb_ps_conv_hs;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // W=8, N=4
  logic [31:0] a_pdin = '0;
  logic        a_pld_valid = 1'b0;
  logic        a_pld_ready;
  logic [7:0]  a_dout;
  logic        a_dout_valid;
  logic        a_dout_ready = 1'b0;
  logic [7:0]  a_din = '0;
  logic [31:0] a_pdout;
  logic        a_pdout_valid;
  logic        a_busy;

  // W=8, N=1
  logic [7:0]  b_pdin = '0;
  logic        b_pld_valid = 1'b0;
  logic        b_pld_ready;
  logic [7:0]  b_dout;
  logic        b_dout_valid;
  logic        b_dout_ready = 1'b0;
  logic [7:0]  b_din = '0;
  logic [7:0]  b_pdout;
  logic        b_pdout_valid;
  logic        b_busy;

  // W=1, N=16
  logic [15:0] c_pdin = '0;
  logic        c_pld_valid = 1'b0;
  logic        c_pld_ready;
  logic [0:0]  c_dout;
  logic        c_dout_valid;
  logic        c_dout_ready = 1'b0;
  logic [0:0]  c_din = '0;
  logic [15:0] c_pdout;
  logic        c_pdout_valid;
  logic        c_busy;

  ps_conv_hs #(.W(8), .N(4)) dut_a (
    .clk(clk), .rst(rst), .pdin(a_pdin), .pld_valid(a_pld_valid), .pld_ready(a_pld_ready),
    .dout(a_dout), .dout_valid(a_dout_valid), .dout_ready(a_dout_ready), .din(a_din),
    .pdout(a_pdout), .pdout_valid(a_pdout_valid), .busy(a_busy)
  );

  ps_conv_hs #(.W(8), .N(1)) dut_b (
    .clk(clk), .rst(rst), .pdin(b_pdin), .pld_valid(b_pld_valid), .pld_ready(b_pld_ready),
    .dout(b_dout), .dout_valid(b_dout_valid), .dout_ready(b_dout_ready), .din(b_din),
    .pdout(b_pdout), .pdout_valid(b_pdout_valid), .busy(b_busy)
  );

  ps_conv_hs #(.W(1), .N(16)) dut_c (
    .clk(clk), .rst(rst), .pdin(c_pdin), .pld_valid(c_pld_valid), .pld_ready(c_pld_ready),
    .dout(c_dout), .dout_valid(c_dout_valid), .dout_ready(c_dout_ready), .din(c_din),
    .pdout(c_pdout), .pdout_valid(c_pdout_valid), .busy(c_busy)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) rst = 1'b0;
      #1;
      chk_cnt++;
      if ({a_dout_valid, a_pld_ready, a_pdout_valid, a_busy} !== 4'b0100)
        $display("FAIL reset_a_ctrl cyc %0d: got %b want 0100", i, {a_dout_valid, a_pld_ready, a_pdout_valid, a_busy});
      else pass_cnt++;
      chk_cnt++;
      if (a_dout !== 8'h00 || a_pdout !== 32'h0)
        $display("FAIL reset_a_data cyc %0d: got dout %h pdout %h want 00 00000000", i, a_dout, a_pdout);
      else pass_cnt++;
    end
    chk_cnt++;
    if ({b_dout_valid, b_pld_ready, b_pdout_valid, b_dout, b_pdout} !== {3'b010, 16'h0})
      $display("FAIL reset_b: got %b %h %h want 010 00 00", {b_dout_valid, b_pld_ready, b_pdout_valid}, b_dout, b_pdout);
    else pass_cnt++;
    chk_cnt++;
    if ({c_dout_valid, c_pld_ready, c_pdout_valid, c_dout, c_pdout} !== {3'b010, 17'h0})
      $display("FAIL reset_c: got %b %b %h want 010 0 0000", {c_dout_valid, c_pld_ready, c_pdout_valid}, c_dout, c_pdout);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] blk = 32'hDEADBEEF;
    a_pdin = blk; a_pld_valid = 1'b1; a_dout_ready = 1'b1;
    tick();
    a_pld_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_din = 8'(i + 1);
      #1;
      chk_cnt++;
      if (a_dout !== blk[31-8*i -: 8])
        $display("FAIL rstmid_dout beat %0d: got %h want %h", i, a_dout, blk[31-8*i -: 8]);
      else pass_cnt++;
      tick();
    end
    rst = 1'b1; a_din = 8'h03;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_cnt++;
      if ({a_dout_valid, a_pdout_valid, a_pld_ready, a_busy} !== 4'b0010 || a_pdout !== 32'h0 || a_dout !== 8'h00)
        $display("FAIL rstmid_idle cyc %0d: got %b pdout %h dout %h want 0010 00000000 00", i,
                 {a_dout_valid, a_pdout_valid, a_pld_ready, a_busy}, a_pdout, a_dout);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_basic;
    logic [31:0] blk = 32'h11223344;
    a_pdin = blk; a_pld_valid = 1'b1; a_dout_ready = 1'b1;
    #1;
    chk_cnt++;
    if (a_pld_ready !== 1'b1) $display("FAIL basic_ready_idle: got %b want 1", a_pld_ready);
    else pass_cnt++;
    tick();
    a_pld_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_din = 8'(8'hA0 + i);
      #1;
      chk_cnt++;
      if (a_dout !== blk[31-8*i -: 8] || a_dout_valid !== 1'b1 || a_busy !== 1'b1)
        $display("FAIL basic_dout beat %0d: got %h v%b b%b want %h v1 b1", i, a_dout, a_dout_valid, a_busy, blk[31-8*i -: 8]);
      else pass_cnt++;
      chk_cnt++;
      if (a_pld_ready !== (i == 3) || a_pdout_valid !== 1'b0)
        $display("FAIL basic_ctrl beat %0d: got rdy %b pv %b want %b 0", i, a_pld_ready, a_pdout_valid, (i == 3));
      else pass_cnt++;
      tick();
    end
    #1;
    chk_cnt++;
    if (a_pdout_valid !== 1'b1 || a_pdout !== 32'hA0A1A2A3)
      $display("FAIL basic_pdout: got v%b %h want v1 a0a1a2a3", a_pdout_valid, a_pdout);
    else pass_cnt++;
    chk_cnt++;
    if (a_dout_valid !== 1'b0 || a_pld_ready !== 1'b1)
      $display("FAIL basic_idle: got v%b rdy %b want v0 rdy 1", a_dout_valid, a_pld_ready);
    else pass_cnt++;
    tick();
    #1;
    chk_cnt++;
    if (a_pdout_valid !== 1'b0 || a_pdout !== 32'hA0A1A2A3)
      $display("FAIL basic_pulse: got v%b %h want v0 a0a1a2a3", a_pdout_valid, a_pdout);
    else pass_cnt++;
  endtask

  task automatic test_backpressure;
    logic [31:0] blk = 32'h11223344;
    a_pdin = blk; a_pld_valid = 1'b1; a_dout_ready = 1'b1;
    tick();
    a_pld_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1 || i == 2) begin
        for (int s = 0; s < 3; s++) begin
          a_dout_ready = 1'b0; a_din = 8'hFF;
          #1;
          chk_cnt++;
          if (a_dout !== blk[31-8*i -: 8] || a_dout_valid !== 1'b1 || a_pld_ready !== 1'b0 || a_pdout_valid !== 1'b0)
            $display("FAIL bp_stall beat %0d cyc %0d: got %h v%b rdy%b pv%b want %h v1 rdy0 pv0", i, s,
                     a_dout, a_dout_valid, a_pld_ready, a_pdout_valid, blk[31-8*i -: 8]);
          else pass_cnt++;
          tick();
        end
      end
      a_dout_ready = 1'b1; a_din = 8'(8'h60 + i);
      #1;
      chk_cnt++;
      if (a_dout !== blk[31-8*i -: 8])
        $display("FAIL bp_dout beat %0d: got %h want %h", i, a_dout, blk[31-8*i -: 8]);
      else pass_cnt++;
      tick();
    end
    #1;
    chk_cnt++;
    if (a_pdout_valid !== 1'b1 || a_pdout !== 32'h60616263 || a_dout_valid !== 1'b0)
      $display("FAIL bp_pdout: got pv%b %h v%b want pv1 60616263 v0", a_pdout_valid, a_pdout, a_dout_valid);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back;
    logic [63:0] blk = 64'h1122334455667788;
    int pulses = 0;
    a_pdin = blk[63:32]; a_pld_valid = 1'b1; a_dout_ready = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      a_din = 8'(8'hB0 + i);
      a_pld_valid = (i == 3);
      a_pdin = blk[31:0];
      #1;
      if (a_pdout_valid === 1'b1) pulses++;
      chk_cnt++;
      if (a_dout !== blk[63-8*i -: 8] || a_dout_valid !== 1'b1)
        $display("FAIL b2b_dout beat %0d: got %h v%b want %h v1", i, a_dout, a_dout_valid, blk[63-8*i -: 8]);
      else pass_cnt++;
      if (i == 3) begin
        chk_cnt++;
        if (a_pld_ready !== 1'b1) $display("FAIL b2b_ready_last: got %b want 1", a_pld_ready);
        else pass_cnt++;
      end
      if (i == 4) begin
        chk_cnt++;
        if (a_pdout_valid !== 1'b1 || a_pdout !== 32'hB0B1B2B3)
          $display("FAIL b2b_pdout1: got pv%b %h want pv1 b0b1b2b3", a_pdout_valid, a_pdout);
        else pass_cnt++;
      end
      tick();
    end
    a_pld_valid = 1'b0;
    #1;
    if (a_pdout_valid === 1'b1) pulses++;
    chk_cnt++;
    if (a_pdout !== 32'hB4B5B6B7 || a_pdout_valid !== 1'b1 || a_dout_valid !== 1'b0)
      $display("FAIL b2b_pdout2: got pv%b %h v%b want pv1 b4b5b6b7 v0", a_pdout_valid, a_pdout, a_dout_valid);
    else pass_cnt++;
    tick();
    #1;
    if (a_pdout_valid === 1'b1) pulses++;
    chk_cnt++;
    if (pulses !== 2) $display("FAIL b2b_pulses: got %0d want 2", pulses);
    else pass_cnt++;
  endtask

  task automatic test_n1;
    b_pdin = 8'h10; b_pld_valid = 1'b1; b_dout_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      b_din = 8'(8'hC0 + i);
      b_pdin = 8'(8'h11 + i);
      b_pld_valid = (i < 3);
      #1;
      chk_cnt++;
      if (b_dout !== 8'(8'h10 + i) || b_dout_valid !== 1'b1 || b_pld_ready !== 1'b1)
        $display("FAIL n1_dout beat %0d: got %h v%b rdy%b want %h v1 rdy1", i, b_dout, b_dout_valid, b_pld_ready, 8'(8'h10 + i));
      else pass_cnt++;
      if (i > 0) begin
        chk_cnt++;
        if (b_pdout_valid !== 1'b1 || b_pdout !== 8'(8'hC0 + i - 1))
          $display("FAIL n1_pdout beat %0d: got pv%b %h want pv1 %h", i, b_pdout_valid, b_pdout, 8'(8'hC0 + i - 1));
        else pass_cnt++;
      end
      tick();
    end
    b_pld_valid = 1'b0;
    #1;
    chk_cnt++;
    if (b_pdout_valid !== 1'b1 || b_pdout !== 8'hC3 || b_dout_valid !== 1'b0)
      $display("FAIL n1_end: got pv%b %h v%b want pv1 c3 v0", b_pdout_valid, b_pdout, b_dout_valid);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_n16;
    logic [15:0] pblk = 16'hA5C3;
    logic [15:0] sblk = 16'h3C96;
    int bad = 0;
    c_pdin = pblk; c_pld_valid = 1'b1; c_dout_ready = 1'b1;
    tick();
    c_pld_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      c_din = sblk[15-i];
      #1;
      if (c_dout[0] !== pblk[15-i] || c_dout_valid !== 1'b1 || c_pld_ready !== (i == 15)) begin
        bad++;
        $display("FAIL n16_beat %0d: got d%b v%b rdy%b want d%b v1 rdy%b", i, c_dout, c_dout_valid, c_pld_ready, pblk[15-i], (i == 15));
      end
      tick();
    end
    chk_cnt++;
    if (bad == 0) pass_cnt++;
    #1;
    chk_cnt++;
    if (c_pdout_valid !== 1'b1 || c_pdout !== 16'h3C96 || c_busy !== 1'b0)
      $display("FAIL n16_pdout: got pv%b %h busy%b want pv1 3c96 busy0", c_pdout_valid, c_pdout, c_busy);
    else pass_cnt++;
    tick();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_reset_mid();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_n1();
    test_n16();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
